// File: rtl/result_fifo_packer_if.sv
// Stream-in / FIFO-out bundle for result_fifo_packer.
// master is the packer side, slave the surrounding pipeline.
interface result_fifo_packer_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  in_valid;
  logic [DATA_WIDTH-1:0] in_data;
  logic                  in_ready;
  logic [DATA_WIDTH:0]   fifo_data;
  logic                  fifo_wrreq;
  logic                  fifo_full;
  logic                  img_done;
  logic                  done;

  modport master (
    input  in_valid,
    input  in_data,
    input  fifo_full,
    output in_ready,
    output fifo_data,
    output fifo_wrreq,
    output img_done,
    output done
  );

  modport slave (
    output in_valid,
    output in_data,
    output fifo_full,
    input  in_ready,
    input  fifo_data,
    input  fifo_wrreq,
    input  img_done,
    input  done
  );
endinterface

// File: rtl/result_fifo_packer.sv
// Buffers one image of scores, tracks the arg-max, then drains
// {is_max, score} words into the output FIFO for NUM_IMG images.
module result_fifo_packer #(
  parameter int DATA_WIDTH = 32,
  parameter int WORDS      = 49,
  parameter int NUM_IMG    = 1
) (
  input logic                  clock,
  input logic                  resetn,
  result_fifo_packer_if.master bus
);
  localparam int IW = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam int CW = $clog2(NUM_IMG + 1);
  localparam logic [IW-1:0] LAST = IW'(WORDS - 1);
  localparam logic [CW-1:0] LAST_IMG = CW'(NUM_IMG - 1);

  typedef enum logic [1:0] {
    COLLECT,
    DRAIN,
    DONE
  } state_t;

  state_t state, state_n;

  logic [IW-1:0] wr_idx, wr_idx_n;
  logic [IW-1:0] rd_idx, rd_idx_n;
  logic [IW-1:0] max_idx, max_idx_n;
  logic [CW-1:0] img_cnt, img_cnt_n;
  logic signed [DATA_WIDTH-1:0] max_val, max_val_n;
  logic img_done, img_done_n;
  logic accept;
  logic wrreq;

  logic [DATA_WIDTH-1:0] mem [WORDS];

  always_comb begin
    state_n    = state;
    wr_idx_n   = wr_idx;
    rd_idx_n   = rd_idx;
    max_idx_n  = max_idx;
    max_val_n  = max_val;
    img_cnt_n  = img_cnt;
    img_done_n = 1'b0;
    accept     = 1'b0;
    wrreq      = 1'b0;
    unique case (state)
      COLLECT: begin
        accept = bus.in_valid & resetn;
        if (accept) begin
          wr_idx_n = wr_idx + 1'b1;
          // strict compare keeps the first of equal maxima
          if (wr_idx == '0 || $signed(bus.in_data) > max_val) begin
            max_val_n = $signed(bus.in_data);
            max_idx_n = wr_idx;
          end
          if (wr_idx == LAST) begin
            wr_idx_n = '0;
            rd_idx_n = '0;
            state_n  = DRAIN;
          end
        end
      end
      DRAIN: begin
        wrreq = !bus.fifo_full;
        if (wrreq) begin
          rd_idx_n = rd_idx + 1'b1;
          if (rd_idx == LAST) begin
            rd_idx_n   = '0;
            img_done_n = 1'b1;
            img_cnt_n  = img_cnt + 1'b1;
            state_n    = (img_cnt == LAST_IMG) ? DONE : COLLECT;
          end
        end
      end
      DONE: begin
        state_n = DONE;
      end
      default: begin
        state_n = COLLECT;
      end
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state    <= COLLECT;
      wr_idx   <= '0;
      rd_idx   <= '0;
      max_idx  <= '0;
      max_val  <= '0;
      img_cnt  <= '0;
      img_done <= 1'b0;
    end else begin
      state    <= state_n;
      wr_idx   <= wr_idx_n;
      rd_idx   <= rd_idx_n;
      max_idx  <= max_idx_n;
      max_val  <= max_val_n;
      img_cnt  <= img_cnt_n;
      img_done <= img_done_n;
    end
  end

  // score storage needs no reset; contents are rewritten per image
  always_ff @(posedge clock) begin
    if (accept) begin
      mem[wr_idx] <= bus.in_data;
    end
  end

  assign bus.in_ready   = (state == COLLECT) & resetn;
  assign bus.fifo_wrreq = wrreq;
  assign bus.fifo_data  = {rd_idx == max_idx, mem[rd_idx]};
  assign bus.img_done   = img_done;
  assign bus.done       = (state == DONE);
endmodule

// File: tb/tb_result_fifo_packer.sv
// Randomized bench for result_fifo_packer over three
// WORDS/NUM_IMG configurations against an arg-max model.
module tb_result_fifo_packer;
  logic clock = 1'b0;
  logic resetn = 1'b0;
  always #5 clock = ~clock;

  logic        in_valid   [3];
  logic [31:0] in_data    [3];
  logic        fifo_full  [3];
  logic        in_ready   [3];
  logic [32:0] fifo_data  [3];
  logic        fifo_wrreq [3];
  logic        img_done   [3];
  logic        done       [3];

  for (genvar g = 0; g < 3; g++) begin : g_dut
    result_fifo_packer_if #(.DATA_WIDTH(32)) bus ();
    assign bus.in_valid  = in_valid[g];
    assign bus.in_data   = in_data[g];
    assign bus.fifo_full = fifo_full[g];
    assign in_ready[g]   = bus.in_ready;
    assign fifo_data[g]  = bus.fifo_data;
    assign fifo_wrreq[g] = bus.fifo_wrreq;
    assign img_done[g]   = bus.img_done;
    assign done[g]       = bus.done;
    result_fifo_packer #(
      .DATA_WIDTH(32),
      .WORDS     ((g == 2) ? 1 : 4),
      .NUM_IMG   ((g == 0) ? 1 : ((g == 1) ? 2 : 3))
    ) u_dut (
      .clock (clock),
      .resetn(resetn),
      .bus   (bus.master)
    );
  end

  int total = 0;
  int bad = 0;
  int sel = 0;
  int cyc = 0;
  int full_viol = 0;
  int done_first = -1;
  logic [32:0] obs_q[$];
  int wr_cyc[$];
  int acc_cyc[$];
  int dn_cyc[$];
  int stim_q[$];
  logic [32:0] exp_q[$];

  always @(negedge clock) begin
    cyc = cyc + 1;
    if (fifo_wrreq[sel]) begin
      obs_q.push_back(fifo_data[sel]);
      wr_cyc.push_back(cyc);
      if (fifo_full[sel]) full_viol++;
    end
    if (img_done[sel]) dn_cyc.push_back(cyc);
    if (in_valid[sel] && in_ready[sel]) acc_cyc.push_back(cyc);
    if (done[sel] && done_first < 0) done_first = cyc;
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_all();
    for (int k = 0; k < 3; k++) begin
      in_valid[k]  = 1'b0;
      in_data[k]   = '0;
      fifo_full[k] = 1'b0;
    end
  endtask

  task automatic do_reset();
    idle_all();
    resetn = 1'b0;
    step();
    step();
    resetn = 1'b1;
    step();
  endtask

  // expected stream: every score, flagged where the first maximum sits
  task automatic build_model(input int words);
    logic [31:0] d;
    int mi;
    exp_q.delete();
    for (int b = 0; b < stim_q.size(); b += words) begin
      mi = b;
      for (int i = b + 1; i < b + words; i++)
        if (stim_q[i] > stim_q[mi]) mi = i;
      for (int i = b; i < b + words; i++) begin
        d = stim_q[i];
        exp_q.push_back({i == mi, d});
      end
    end
  endtask

  task automatic run(input int k, input int words, input int nimg,
                     input int fmode, input bit exp_done);
    int n = 0;
    int g;
    int dc;
    int target;
    int ready_bad = 0;
    int stall_bad = 0;
    int t;
    build_model(words);
    sel = k;
    obs_q.delete();
    wr_cyc.delete();
    acc_cyc.delete();
    dn_cyc.delete();
    full_viol = 0;
    done_first = -1;
    for (int img = 0; img < nimg; img++) begin
      for (int w = 0; w < words; w++) begin
        if (fmode == 2 && $urandom_range(0, 3) == 0) begin
          in_valid[k] = 1'b0;
          step();
        end
        in_data[k] = stim_q[n];
        n++;
        in_valid[k] = 1'b1;
        g = 0;
        while (!in_ready[k] && g < 50) begin
          step();
          g++;
        end
        step();
      end
      dc = 0;
      g = 0;
      target = (img + 1) * words;
      while (obs_q.size() < target && g < 400) begin
        case (fmode)
          0: fifo_full[k] = 1'b0;
          1: fifo_full[k] = (dc < 3) || (((dc - 3) % 2) == 1);
          default: fifo_full[k] = ($urandom_range(0, 2) == 0);
        endcase
        in_valid[k] = 1'b1;
        in_data[k] = $urandom;
        if (in_ready[k]) ready_bad++;
        if (fifo_full[k] && fifo_data[k] !== exp_q[obs_q.size()])
          stall_bad++;
        step();
        dc++;
        g++;
      end
      in_valid[k] = 1'b0;
      fifo_full[k] = 1'b0;
    end
    repeat (3) step();

    total++;
    if (obs_q.size() != exp_q.size()) begin
      bad++;
      $display("FAIL write_count: got %0d want %0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      total++;
      if (obs_q[i] !== exp_q[i]) begin
        bad++;
        $display("FAIL word[%0d]: got %h want %h", i, obs_q[i], exp_q[i]);
      end
    end
    total++;
    if (ready_bad != 0) begin
      bad++;
      $display("FAIL ready_in_drain: got %0d want 0", ready_bad);
    end
    total++;
    if (stall_bad != 0) begin
      bad++;
      $display("FAIL stall_data: got %0d want 0", stall_bad);
    end
    total++;
    if (full_viol != 0) begin
      bad++;
      $display("FAIL wrreq_while_full: got %0d want 0", full_viol);
    end
    total++;
    if (acc_cyc.size() != words * nimg) begin
      bad++;
      $display("FAIL accepts: got %0d want %0d", acc_cyc.size(), words * nimg);
    end
    total++;
    if (dn_cyc.size() != nimg) begin
      bad++;
      $display("FAIL img_done_pulses: got %0d want %0d", dn_cyc.size(), nimg);
    end
    total++;
    if (done[k] !== exp_done) begin
      bad++;
      $display("FAIL done_level: got %0b want %0b", done[k], exp_done);
    end
    total++;
    if (fifo_wrreq[k] !== 1'b0) begin
      bad++;
      $display("FAIL idle_wrreq: got %0b want 0", fifo_wrreq[k]);
    end
    if (exp_done) begin
      total++;
      if (in_ready[k] !== 1'b0) begin
        bad++;
        $display("FAIL done_ready: got %0b want 0", in_ready[k]);
      end
      total++;
      if (dn_cyc.size() == 0 || done_first != dn_cyc[dn_cyc.size() - 1]) begin
        bad++;
        $display("FAIL done_timing: got %0d want last img_done", done_first);
      end
    end else begin
      total++;
      if (done_first != -1) begin
        bad++;
        $display("FAIL early_done: got %0d want -1", done_first);
      end
    end
    if (fmode == 0 && acc_cyc.size() == words * nimg &&
        wr_cyc.size() == words * nimg && dn_cyc.size() == nimg) begin
      for (int i = 0; i < nimg; i++) begin
        t = acc_cyc[(i + 1) * words - 1];
        total++;
        if (wr_cyc[i * words] != t + 1 ||
            wr_cyc[(i + 1) * words - 1] != t + words ||
            dn_cyc[i] != t + words + 1) begin
          bad++;
          $display("FAIL latency[%0d]: got %0d/%0d/%0d want %0d/%0d/%0d", i,
                   wr_cyc[i * words], wr_cyc[(i + 1) * words - 1], dn_cyc[i],
                   t + 1, t + words, t + words + 1);
        end
      end
    end
  endtask

  task automatic test_reset();
    idle_all();
    resetn = 1'b0;
    step();
    for (int k = 0; k < 3; k++) begin
      total++;
      if (in_ready[k] !== 1'b0 || fifo_wrreq[k] !== 1'b0 ||
          img_done[k] !== 1'b0 || done[k] !== 1'b0) begin
        bad++;
        $display("FAIL reset_outputs[%0d]: got %b%b%b%b want 0000", k,
                 in_ready[k], fifo_wrreq[k], img_done[k], done[k]);
      end
    end
    resetn = 1'b1;
    step();
    for (int k = 0; k < 3; k++) begin
      total++;
      if (in_ready[k] !== 1'b1 || done[k] !== 1'b0) begin
        bad++;
        $display("FAIL post_reset[%0d]: got %b%b want 10", k, in_ready[k], done[k]);
      end
    end
  endtask

  task automatic test_basic();
    do_reset();
    stim_q = '{5, -3, 9, 2};
    run(0, 4, 1, 0, 1'b1);
  endtask

  task automatic test_ties();
    do_reset();
    stim_q = '{-8, -1, -1, -20};
    run(0, 4, 1, 0, 1'b1);
  endtask

  task automatic test_backpressure();
    do_reset();
    stim_q.delete();
    for (int i = 0; i < 4; i++) stim_q.push_back(int'($urandom_range(0, 40)) - 20);
    run(0, 4, 1, 1, 1'b1);
  endtask

  task automatic test_multi_img();
    do_reset();
    stim_q = '{1, 2, 3, 4, 7, 0, 0, 0};
    run(1, 4, 2, 0, 1'b1);
  endtask

  task automatic test_reset_mid();
    do_reset();
    sel = 1;
    in_valid[1] = 1'b1;
    in_data[1] = 32'd99;
    step();
    in_data[1] = 32'd98;
    step();
    do_reset();
    stim_q = '{0, 0, 0, 1};
    run(1, 4, 1, 0, 1'b0);
  endtask

  task automatic test_words1();
    do_reset();
    stim_q = '{10, -10, 0};
    run(2, 1, 3, 0, 1'b1);
  endtask

  task automatic test_random();
    int k;
    int words;
    int nimg;
    for (int it = 0; it < 12; it++) begin
      k = $urandom_range(0, 2);
      words = (k == 2) ? 1 : 4;
      nimg = k + 1;
      stim_q.delete();
      for (int i = 0; i < words * nimg; i++) begin
        if ($urandom_range(0, 1) == 0)
          stim_q.push_back(int'($urandom_range(0, 6)) - 3);
        else
          stim_q.push_back(int'($urandom));
      end
      do_reset();
      run(k, words, nimg, $urandom_range(0, 2), 1'b1);
    end
  endtask

  initial begin
    idle_all();
    test_reset();
    test_basic();
    test_ties();
    test_backpressure();
    test_multi_img();
    test_reset_mid();
    test_words1();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
